id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter NOP_ALUFUN, default 6'b000000, ALUFun value driven while EX holds a bubble.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  ID slot holds a real instruction.
REQ-005 id_ALUFun  input  6  ALU function code for this instruction.
REQ-006 id_rs, id_rt  input  5 each  source register numbers.
REQ-007 id_rs_data, id_rt_data  input  32 each  register-file read values.
REQ-008 id_imm  input  32  extended immediate; id_ALUSrcB  input  1  1 = B operand is immediate.
REQ-009 id_rd  input  5  destination register; id_RegWrite, id_MemRead, id_MemWrite  input  1 each.
REQ-010 exmem_RegWrite  input  1; exmem_rd  input  5; exmem_result  input  32  EX/MEM writeback candidate.
REQ-011 memwb_RegWrite  input  1; memwb_rd  input  5; memwb_result  input  32  MEM/WB writeback candidate.
REQ-012 flush  input  1  squash the instruction entering EX (branch/jump redirect).
REQ-013 stall  output  1  load-use hazard; upstream holds PC and IF/ID.
REQ-014 ex_valid  output  1; ex_ALUFun  output  6; ex_A, ex_B  output  32 each  ALU operands.
REQ-015 ex_store_data  output  32  forwarded rt value for stores.
REQ-016 ex_rd  output  5; ex_RegWrite, ex_MemRead, ex_MemWrite  output  1 each.

Function
REQ-017 Register bank captures all id_* fields each rising edge; captured values appear on ex_* outputs one cycle later (latency 1).
REQ-018 Bubble definition: valid=0, ALUFun=NOP_ALUFUN, RegWrite=MemRead=MemWrite=0, rd=0, rs=rt=0, all data fields 0.
REQ-019 Capture priority per edge: reset > flush > stall > normal; flush and stall each load a bubble; id_valid=0 also loads a bubble.
REQ-020 stall = ex_valid & ex_MemRead & (ex_rd!=0) & id_valid & (ex_rd==id_rs | ex_rd==id_rt) & ~flush; combinational from current EX state and ID inputs.
REQ-021 Stall lasts exactly one cycle per load-use pair: the inserted bubble has MemRead=0, so stall drops next cycle.
REQ-022 Forwarding for stored rs (same rule for rt): if exmem_RegWrite & exmem_rd!=0 & exmem_rd==rs -> exmem_result; else if memwb_RegWrite & memwb_rd!=0 & memwb_rd==rs -> memwb_result; else stored rs_data.
REQ-023 EX/MEM match SHALL take priority over MEM/WB when both hit the same register.
REQ-024 Register 0 is never forwarded; stored data for r0 passes unchanged.
REQ-025 ex_A = forwarded rs; ex_B = stored ALUSrcB ? stored imm : forwarded rt; ex_store_data = forwarded rt regardless of ALUSrcB.
REQ-026 Forwarding is combinational on current-cycle exmem_*/memwb_* inputs; no extra latency.
REQ-027 ex_ALUFun is passed through unmodified from the captured id_ALUFun (all 6 bits, including [5:4] class select).
REQ-028 While ex_valid=0, ex_A, ex_B, ex_store_data SHALL still follow REQ-022..025 (on zeroed fields) but control outputs stay 0.

Reset
REQ-029 reset=1 at a rising edge loads a bubble; all registered outputs per REQ-018 from the following cycle; stall=0 while EX holds a bubble.
REQ-030 reset asserted mid-stall or mid-flush: bubble loaded, no pending hazard retained; first edge after deassertion captures id_* normally.

Verification
REQ-031 Pass-through: id_ALUFun=6'b010110, rs_data=5, rt_data=7, ALUSrcB=0, no forwarding -> next cycle ex_ALUFun=6'b010110, ex_A=5, ex_B=7, ex_valid=1.
REQ-032 Double forward: EX rs=3, exmem_rd=3 result 0x11, memwb_rd=3 result 0x22, both RegWrite=1 -> ex_A=0x11; drop exmem_RegWrite -> ex_A=0x22.
REQ-033 r0 guard: rs=0, exmem_rd=0, exmem_RegWrite=1, exmem_result=0xFFFF -> ex_A=stored rs_data (0).
REQ-034 Load-use: EX holds lw to r8 (MemRead=1), ID valid with id_rt=8 -> stall=1 for one cycle, EX shows bubble next cycle, stall=0 after; instruction captured on the following edge.
REQ-035 Flush vs stall: hazard condition present and flush=1 -> stall=0, bubble captured; ALUSrcB=1, imm=0xFFFFFFFC, rt forwarded 9 -> ex_B=0xFFFFFFFC, ex_store_data=9.
REQ-036 Reset: valid instruction in EX, reset pulsed one cycle -> next cycle ex_valid=0, ex_ALUFun=NOP_ALUFUN, ex_rd=0, all control outputs 0, stall=0.

Source files
------------

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall detection and
//            EX/MEM, MEM/WB operand forwarding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter logic [5:0] NOP_ALUFUN = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_ALUFun,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_ALUSrcB,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic [5:0]  ex_ALUFun,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite
);

  logic        r_valid;
  logic [5:0]  r_alufun;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic        r_alusrcb;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;

  logic        w_load_bubble;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
  function automatic logic [31:0] fwd_operand(input logic [4:0] src, input logic [31:0] stored);
    logic [31:0] value;
    value = stored;
    if (src != 5'd0) begin
      if (exmem_RegWrite && (exmem_rd == src))
        value = exmem_result;
      else if (memwb_RegWrite && (memwb_rd == src))
        value = memwb_result;
    end
    return value;
  endfunction

  always_comb begin
    stall = r_valid && r_memread && (r_rd != 5'd0) && id_valid &&
            ((r_rd == id_rs) || (r_rd == id_rt)) && !flush;
  end

  assign w_load_bubble = reset || flush || stall || !id_valid;

  always_ff @(posedge clk) begin
    if (w_load_bubble) begin
      r_valid    <= 1'b0;
      r_alufun   <= NOP_ALUFUN;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_rs_data  <= 32'd0;
      r_rt_data  <= 32'd0;
      r_imm      <= 32'd0;
      r_alusrcb  <= 1'b0;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else begin
      r_valid    <= 1'b1;
      r_alufun   <= id_ALUFun;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_alusrcb  <= id_ALUSrcB;
      r_rd       <= id_rd;
      r_regwrite <= id_RegWrite;
      r_memread  <= id_MemRead;
      r_memwrite <= id_MemWrite;
    end
  end

  always_comb begin
    w_fwd_rs = fwd_operand(r_rs, r_rs_data);
    w_fwd_rt = fwd_operand(r_rt, r_rt_data);
  end

  assign ex_A          = w_fwd_rs;
  assign ex_B          = r_alusrcb ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign ex_valid      = r_valid;
  assign ex_ALUFun     = r_alufun;
  assign ex_rd         = r_rd;
  assign ex_RegWrite   = r_regwrite;
  assign ex_MemRead    = r_memread;
  assign ex_MemWrite   = r_memwrite;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_stage
// Brief    : Directed and randomized bench for id_ex_stage with a reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  localparam logic [5:0] NOP = 6'b100001;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [5:0]  id_ALUFun;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_ALUSrcB, id_RegWrite, id_MemRead, id_MemWrite;
  logic        exmem_RegWrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_RegWrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        stall, ex_valid;
  logic [5:0]  ex_ALUFun;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.NOP_ALUFUN(NOP)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUFun(id_ALUFun),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ALUSrcB(id_ALUSrcB), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_ALUFun(ex_ALUFun),
    .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite)
  );

  // Model of the instruction sitting in EX.
  typedef struct {
    bit        valid;
    bit [5:0]  fun;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
    bit        srcb, rw, mr, mw;
  } slot_t;

  slot_t m;

  function automatic slot_t bubble();
    slot_t b;
    b = '{valid: 0, fun: NOP, rs: 0, rt: 0, rd: 0, rsd: 0, rtd: 0, imm: 0,
          srcb: 0, rw: 0, mr: 0, mw: 0};
    return b;
  endfunction

  // Value a source register should read once in-flight writes are considered.
  function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] stored);
    if (r == 0) return stored;
    if (exmem_RegWrite && exmem_rd == r) return exmem_result;
    if (memwb_RegWrite && memwb_rd == r) return memwb_result;
    return stored;
  endfunction

  function automatic bit hazard();
    return m.valid && m.mr && m.rd != 0 && id_valid &&
           (m.rd == id_rs || m.rd == id_rt) && !flush;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic cycle();
    slot_t nxt;
    @(negedge clk);
    check("stall",    {31'd0, stall}, {31'd0, hazard()});
    check("valid",    {31'd0, ex_valid}, {31'd0, m.valid});
    check("alufun",   {26'd0, ex_ALUFun}, {26'd0, m.fun});
    check("rd",       {27'd0, ex_rd}, {27'd0, m.rd});
    check("ctl",      {29'd0, ex_RegWrite, ex_MemRead, ex_MemWrite}, {29'd0, m.rw, m.mr, m.mw});
    check("A",        ex_A, operand(m.rs, m.rsd));
    check("B",        ex_B, m.srcb ? m.imm : operand(m.rt, m.rtd));
    check("store",    ex_store_data, operand(m.rt, m.rtd));
    if (reset || flush || hazard() || !id_valid) nxt = bubble();
    else nxt = '{valid: 1, fun: id_ALUFun, rs: id_rs, rt: id_rt, rd: id_rd,
                 rsd: id_rs_data, rtd: id_rt_data, imm: id_imm, srcb: id_ALUSrcB,
                 rw: id_RegWrite, mr: id_MemRead, mw: id_MemWrite};
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic set_id(input bit v, input bit [5:0] f, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit srcb, input bit [4:0] rd, input bit rw, input bit mr, input bit mw);
    id_valid = v; id_ALUFun = f; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_ALUSrcB = srcb; id_rd = rd; id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
  endtask

  task automatic no_fwd();
    exmem_RegWrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_RegWrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    m = bubble();
    reset = 1; flush = 0;
    no_fwd();
    set_id(1, 6'h3F, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 0, 5'd6, 1, 1, 1);
    @(posedge clk); #1;
    cycle();
    reset = 0;
    #1;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_fun", {26'd0, ex_ALUFun}, {26'd0, NOP});
    check("rst_stall", {31'd0, stall}, 32'd0);

    // Plain pass-through.
    set_id(1, 6'b010110, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 0, 5'd9, 1, 0, 0);
    cycle(); #1;
    check("pt_fun", {26'd0, ex_ALUFun}, 32'h16);
    check("pt_A", ex_A, 32'd5);
    check("pt_B", ex_B, 32'd7);
    check("pt_valid", {31'd0, ex_valid}, 32'd1);

    // Both producers target r3: EX/MEM first, then MEM/WB alone.
    set_id(1, 6'h01, 5'd3, 5'd0, 32'h99, 32'h0, 32'h0, 0, 5'd10, 1, 0, 0);
    cycle();
    set_id(0, 6'h00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    exmem_RegWrite = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_RegWrite = 1; memwb_rd = 3; memwb_result = 32'h22;
    #1 check("dfwd_exmem", ex_A, 32'h11);
    exmem_RegWrite = 0;
    #1 check("dfwd_memwb", ex_A, 32'h22);
    cycle();

    // r0 is never forwarded.
    no_fwd();
    set_id(1, 6'h02, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd11, 1, 0, 0);
    cycle();
    exmem_RegWrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    #1 check("r0_guard", ex_A, 32'h0);
    no_fwd();

    // Load-use: lw r8 then a consumer of r8.
    set_id(1, 6'h20, 5'd1, 5'd2, 32'h0, 32'h0, 32'h4, 1, 5'd8, 1, 1, 0);
    cycle();
    set_id(1, 6'h05, 5'd1, 5'd8, 32'h0, 32'h0, 32'h0, 0, 5'd12, 1, 0, 0);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    cycle(); #1;
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_stall_drop", {31'd0, stall}, 32'd0);
    cycle(); #1;
    check("lu_capture", {26'd0, ex_ALUFun}, 32'h05);
    check("lu_capture_v", {31'd0, ex_valid}, 32'd1);

    // Flush beats stall; then immediate operand with forwarded store data.
    set_id(1, 6'h20, 5'd1, 5'd2, 32'h0, 32'h0, 32'h4, 1, 5'd8, 1, 1, 0);
    cycle();
    set_id(1, 6'h05, 5'd8, 5'd2, 32'h0, 32'h0, 32'h0, 0, 5'd12, 1, 0, 0);
    flush = 1;
    #1 check("fl_stall", {31'd0, stall}, 32'd0);
    cycle(); flush = 0; #1;
    check("fl_bubble", {31'd0, ex_valid}, 32'd0);
    set_id(1, 6'h11, 5'd1, 5'd5, 32'h0, 32'h1, 32'hFFFFFFFC, 1, 5'd13, 0, 0, 1);
    cycle();
    memwb_RegWrite = 1; memwb_rd = 5; memwb_result = 32'd9;
    #1;
    check("imm_B", ex_B, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'd9);
    no_fwd();

    // Reset with a valid instruction in EX.
    reset = 1;
    cycle(); reset = 0; #1;
    check("r_valid", {31'd0, ex_valid}, 32'd0);
    check("r_fun", {26'd0, ex_ALUFun}, {26'd0, NOP});
    check("r_rd", {27'd0, ex_rd}, 32'd0);
    check("r_ctl", {29'd0, ex_RegWrite, ex_MemRead, ex_MemWrite}, 32'd0);
    check("r_stall", {31'd0, stall}, 32'd0);

    // Reset mid-stall: no hazard survives, next edge captures.
    set_id(1, 6'h20, 5'd1, 5'd2, 32'h0, 32'h0, 32'h4, 1, 5'd8, 1, 1, 0);
    cycle();
    set_id(1, 6'h07, 5'd8, 5'd2, 32'h0, 32'h0, 32'h0, 0, 5'd14, 1, 0, 0);
    reset = 1;
    cycle(); reset = 0; #1;
    check("rs_stall", {31'd0, stall}, 32'd0);
    cycle(); #1;
    check("rs_capture", {26'd0, ex_ALUFun}, 32'h07);

    // Randomized traffic; small register numbers make collisions frequent.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 6'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
      exmem_RegWrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_RegWrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
